// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Groups the requester handshakes (A = CPU, B = DMA/loader) and the shared
// memory bus served by mem_arbiter.
//   slave  : the arbiter's view. It samples req/we/lock/addr/wdata and
//            mem_rdata, and drives gnt/ack/rdata and mem_addr/mem_wdata/
//            mem_dir/mem_load.
//   master : the requester and memory side, with every direction reversed.
// Parameters: WIDTH (data bits), WIDTH_ADDR (address bits).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int WIDTH_ADDR = 16
);
    logic                  a_req;
    logic                  a_we;
    logic                  a_lock;
    logic [WIDTH_ADDR-1:0] a_addr;
    logic [WIDTH-1:0]      a_wdata;
    logic                  a_gnt;
    logic                  a_ack;
    logic [WIDTH-1:0]      a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic                  b_lock;
    logic [WIDTH_ADDR-1:0] b_addr;
    logic [WIDTH-1:0]      b_wdata;
    logic                  b_gnt;
    logic                  b_ack;
    logic [WIDTH-1:0]      b_rdata;

    logic [WIDTH_ADDR-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  mem_dir;
    logic                  mem_load;
    logic [WIDTH-1:0]      mem_rdata;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        output a_gnt, a_ack, a_rdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        output b_gnt, b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_dir, mem_load,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        input  a_gnt, a_ack, a_rdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        input  b_gnt, b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_dir, mem_load,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter for a single-port memory. Each access takes four
// cycles: IDLE -> SETUP -> XFER -> DONE. Contention is resolved round-robin.
// After reset the last-served pointer is B, so A wins the first contention.
//
// Ports
//   clk  : single clock; all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : mem_arbiter_if.slave, which carries the A and B requester
//          handshakes and the memory bus
//
// Build option
//   MEM_ARBITER_LOCK_EN : when defined, an owner whose lock input is high in
//   DONE keeps the bus. The other requester is then ignored until the owner
//   finishes an access with lock low, or leaves req low for one IDLE cycle.
//   When undefined, a_lock and b_lock are ignored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | sample requests and pick a winner; bus parked (dir=1, load=0)
// SETUP | winner granted; latched address, data and direction on bus
// XFER  | write strobe (writes only); read data valid from memory
// DONE  | ack to owner; read data registered; bus released next edge
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH      = 8,
    parameter int WIDTH_ADDR = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_owner_b;   // current owner: 0 = A, 1 = B
    logic                  r_last_b;    // last served:   0 = A, 1 = B
    logic                  r_we;

    logic                  r_a_gnt;
    logic                  r_a_ack;
    logic [WIDTH-1:0]      r_a_rdata;
    logic                  r_b_gnt;
    logic                  r_b_ack;
    logic [WIDTH-1:0]      r_b_rdata;

    logic [WIDTH_ADDR-1:0] r_mem_addr;
    logic [WIDTH-1:0]      r_mem_wdata;
    logic                  r_mem_dir;
    logic                  r_mem_load;

    logic                  w_a_elig;
    logic                  w_b_elig;
    logic                  w_grant;
    logic                  w_win_b;
    logic                  w_win_we;
    logic [WIDTH_ADDR-1:0] w_win_addr;
    logic [WIDTH-1:0]      w_win_wdata;

`ifdef MEM_ARBITER_LOCK_EN
    logic                  r_locked;
    logic                  r_lock_owner_b;
    logic                  w_lock_owner_req;
    logic                  w_owner_lock;

    assign w_lock_owner_req = r_lock_owner_b ? bus.b_req  : bus.a_req;
    assign w_owner_lock     = r_owner_b      ? bus.b_lock : bus.a_lock;
`else
    logic                  w_unused_lock;

    assign w_unused_lock = bus.a_lock ^ bus.b_lock;
`endif

    // Winner selection. This is only acted on in IDLE.
    always_comb begin
        w_a_elig = bus.a_req;
        w_b_elig = bus.b_req;
`ifdef MEM_ARBITER_LOCK_EN
        // While a lock is held, only the lock owner may compete.
        if (r_locked) begin
            if (r_lock_owner_b) begin
                w_a_elig = 1'b0;
            end else begin
                w_b_elig = 1'b0;
            end
        end
`endif
        w_grant = w_a_elig | w_b_elig;
        if (w_a_elig && w_b_elig) begin
            w_win_b = ~r_last_b;
        end else begin
            w_win_b = w_b_elig;
        end
        w_win_we    = w_win_b ? bus.b_we    : bus.a_we;
        w_win_addr  = w_win_b ? bus.b_addr  : bus.a_addr;
        w_win_wdata = w_win_b ? bus.b_wdata : bus.a_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner_b   <= 1'b1;
            r_last_b    <= 1'b1;
            r_we        <= 1'b0;
            r_a_gnt     <= 1'b0;
            r_a_ack     <= 1'b0;
            r_a_rdata   <= '0;
            r_b_gnt     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_b_rdata   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_dir   <= 1'b1;
            r_mem_load  <= 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
            r_locked       <= 1'b0;
            r_lock_owner_b <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        // The winner's request is captured here. Later input
                        // changes do not affect this access.
                        r_owner_b   <= w_win_b;
                        r_we        <= w_win_we;
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_dir   <= ~w_win_we;
                        r_a_gnt     <= ~w_win_b;
                        r_b_gnt     <= w_win_b;
                        r_state     <= ST_SETUP;
                    end
`ifdef MEM_ARBITER_LOCK_EN
                    // An owner that leaves req low for an IDLE cycle gives up the lock.
                    if (r_locked && !w_lock_owner_req) begin
                        r_locked <= 1'b0;
                    end
`endif
                end

                ST_SETUP: begin
                    r_mem_load <= r_we;
                    r_state    <= ST_XFER;
                end

                ST_XFER: begin
                    r_mem_load <= 1'b0;
                    if (r_owner_b) begin
                        r_b_ack <= 1'b1;
                        if (!r_we) begin
                            r_b_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_a_ack <= 1'b1;
                        if (!r_we) begin
                            r_a_rdata <= bus.mem_rdata;
                        end
                    end
                    r_state <= ST_DONE;
                end

                ST_DONE: begin
                    r_a_ack   <= 1'b0;
                    r_b_ack   <= 1'b0;
                    r_a_gnt   <= 1'b0;
                    r_b_gnt   <= 1'b0;
                    r_mem_dir <= 1'b1;
                    r_last_b  <= r_owner_b;
`ifdef MEM_ARBITER_LOCK_EN
                    r_locked       <= w_owner_lock;
                    r_lock_owner_b <= r_owner_b;
`endif
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_gnt     = r_a_gnt;
    assign bus.a_ack     = r_a_ack;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_gnt     = r_b_gnt;
    assign bus.b_ack     = r_b_ack;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_dir   = r_mem_dir;
    assign bus.mem_load  = r_mem_load;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter_if #(.WIDTH(8), .WIDTH_ADDR(16)) bus ();

    mem_arbiter #(.WIDTH(8), .WIDTH_ADDR(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge when load is high.
    logic [7:0] mem [65536];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'hFF;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_load) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_lock = 1'b0;
        bus.a_addr = '0;  bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_lock = 1'b0;
        bus.b_addr = '0;  bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_gnt"},    bus.a_gnt, 0);
        check({tag, "_b_gnt"},    bus.b_gnt, 0);
        check({tag, "_a_ack"},    bus.a_ack, 0);
        check({tag, "_b_ack"},    bus.b_ack, 0);
        check({tag, "_mem_load"}, bus.mem_load, 0);
        check({tag, "_mem_dir"},  bus.mem_dir, 1);
    endtask

    // One uncontended access. Requester inputs are scrambled right after
    // the grant to show that the access uses the values latched at IDLE.
    task automatic single_access(input logic use_b, input logic we,
                                 input logic [15:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata);
        if (use_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        tick(); // SETUP
        if (use_b) begin
            bus.b_we = ~we; bus.b_addr = ~addr; bus.b_wdata = ~wdata;
        end else begin
            bus.a_we = ~we; bus.a_addr = ~addr; bus.a_wdata = ~wdata;
        end
        check("setup_a_gnt", bus.a_gnt, !use_b);
        check("setup_b_gnt", bus.b_gnt, use_b);
        check("setup_addr",  bus.mem_addr, addr);
        check("setup_dir",   bus.mem_dir, !we);
        check("setup_load",  bus.mem_load, 0);
        tick(); // XFER
        check("xfer_load", bus.mem_load, we);
        check("xfer_addr", bus.mem_addr, addr);
        check("xfer_dir",  bus.mem_dir, !we);
        check("xfer_gnt",  use_b ? bus.b_gnt : bus.a_gnt, 1);
        if (we) begin
            check("xfer_wdata", bus.mem_wdata, wdata);
        end
        tick(); // DONE
        check("done_own_ack",   use_b ? bus.b_ack : bus.a_ack, 1);
        check("done_other_ack", use_b ? bus.a_ack : bus.b_ack, 0);
        check("done_load",      bus.mem_load, 0);
        check("done_gnt",       use_b ? bus.b_gnt : bus.a_gnt, 1);
        if (!we) begin
            check("done_rdata", use_b ? bus.b_rdata : bus.a_rdata, exp_rdata);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick(); // IDLE
        check_idle_outputs("post");
        check("post_addr_held", bus.mem_addr, addr);
    endtask

    // Both requesters compete. Records the owner of the first four grants.
    // Bit i of exp_b is 1 when grant i should go to B.
    task automatic contention(input string tag, input logic [3:0] exp_b,
                              input logic a_lock, input int a_stop_after,
                              input logic chk_spacing);
        int   n_grants   = 0;
        int   a_acks     = 0;
        int   last_start = 0;
        logic pa         = 1'b0;
        logic pb         = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_lock = a_lock;
        bus.a_addr = 16'h0100; bus.a_wdata = 8'h11;
        bus.b_req = 1'b1; bus.b_we = 1'b1;
        bus.b_addr = 16'h0200; bus.b_wdata = 8'h22;
        for (int c = 0; c < 60 && n_grants < 4; c++) begin
            tick();
            check({tag, "_gnt_overlap"}, bus.a_gnt & bus.b_gnt, 0);
            if ((bus.a_gnt && !pa) || (bus.b_gnt && !pb)) begin
                check($sformatf("%s_grant%0d_is_b", tag, n_grants), bus.b_gnt, exp_b[n_grants]);
                if (chk_spacing && n_grants > 0) begin
                    check($sformatf("%s_spacing%0d", tag, n_grants), c - last_start, 4);
                end
                last_start = c;
                n_grants++;
            end
            if (bus.a_ack) begin
                a_acks++;
                if (a_acks == a_stop_after) begin
                    bus.a_req  = 1'b0;
                    bus.a_lock = 1'b0;
                end
            end
            pa = bus.a_gnt;
            pb = bus.b_gnt;
        end
        check({tag, "_grants_seen"}, n_grants, 4);
        clear_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
        end
        check_idle_outputs({tag, "_end"});
    endtask

    initial begin
        logic [3:0] exp_lock_order;

        clear_inputs();
        do_reset();

        // Reset values, and the FSM stays in IDLE with no requests.
        check_idle_outputs("reset");
        check("reset_mem_addr",  bus.mem_addr, 0);
        check("reset_mem_wdata", bus.mem_wdata, 0);
        check("reset_a_rdata",   bus.a_rdata, 0);
        check("reset_b_rdata",   bus.b_rdata, 0);
        tick();
        tick();
        check_idle_outputs("idle_noreq");

        // A read of unwritten location 0 returns the erased value.
        single_access(1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF);

        // A writes 0x5A to 0x1234, then reads it back.
        single_access(1'b0, 1'b1, 16'h1234, 8'h5A, 8'h00);
        single_access(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A);
        check("b_rdata_untouched", bus.b_rdata, 0);

        // B writes and reads. A's read data must hold.
        single_access(1'b1, 1'b1, 16'h00FF, 8'hC3, 8'h00);
        single_access(1'b1, 1'b0, 16'h00FF, 8'h00, 8'hC3);
        check("a_rdata_held", bus.a_rdata, 8'h5A);
        check("mem_written",  mem[16'h00FF], 8'hC3);

        // Round-robin from reset: A, B, A, B at four cycles per access.
        do_reset();
        contention("rr", 4'b1010, 1'b0, 0, 1'b1);

        // A holds lock for three writes while B keeps requesting.
        do_reset();
`ifdef MEM_ARBITER_LOCK_EN
        exp_lock_order = 4'b1000;
`else
        exp_lock_order = 4'b1010;
`endif
        contention("lock", exp_lock_order, 1'b1, 3, 1'b0);

        // A reset during the XFER cycle of a B write aborts the access.
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0042; bus.b_wdata = 8'h77;
        tick(); // SETUP
        check("abort_setup_b_gnt", bus.b_gnt, 1);
        tick(); // XFER
        check("abort_xfer_load", bus.mem_load, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.b_req = 1'b0;
        check_idle_outputs("abort");
        check("abort_mem_addr",  bus.mem_addr, 0);
        check("abort_mem_wdata", bus.mem_wdata, 0);
        check("abort_b_rdata",   bus.b_rdata, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_no_ack%0d", c), bus.b_ack, 0);
            check($sformatf("abort_no_load%0d", c), bus.mem_load, 0);
        end
        // The arbiter must be back in IDLE, so a new access begins on the next edge.
        single_access(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
